// File: rtl/stack_core_controller.sv
// stack_core_controller
//
// Fetch/execute engine for the 8-bit stack machine. Sequences a FETCH / DECODE / MEM / STOP
// state machine over a shared 32x8 instruction/data memory. The core owns the program counter,
// the instruction register, the operand stack and the ALU.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   mem_rdata  combinational read data for mem_addr while mem_rd=1
//   mem_addr   memory address (pc unless the MEM state targets operand A)
//   mem_rd     read strobe (FETCH, and MEM for PUSH)
//   mem_wr     write strobe (MEM for POP); the memory writes on the same rising edge
//   mem_wdata  write data (always the top of stack)
//   halted     core stopped, by HALT or by a stack fault
//   err        stack overflow/underflow fault
//   pc         current program counter
//   sp         number of valid stack entries
//   tos        top of stack, 0 when the stack is empty
module stack_core_controller #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SPW   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     mem_rdata,
    output logic [4:0]     mem_addr,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic [7:0]     mem_wdata,
    output logic           halted,
    output logic           err,
    output logic [4:0]     pc,
    output logic [SPW-1:0] sp,
    output logic [7:0]     tos
);

    // Storage is sized to the full pointer range so every sp-derived index is in bounds;
    // entries at or above DEPTH are never written because overflow is trapped in DECODE.
    localparam int unsigned    Entries = 2 ** SPW;
    localparam logic [SPW-1:0] SpFull  = SPW'(DEPTH);
    localparam logic [SPW-1:0] SpOne   = SPW'(1);
    localparam logic [SPW-1:0] SpTwo   = SPW'(2);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpAnd  = 3'b010;
    localparam logic [2:0] OpHalt = 3'b011;
    localparam logic [2:0] OpPush = 3'b100;
    localparam logic [2:0] OpPop  = 3'b101;
    localparam logic [2:0] OpJmp  = 3'b110;
    localparam logic [2:0] OpJz   = 3'b111;

    typedef enum logic [1:0] {
        StFetch,
        StDecode,
        StMem,
        StStop
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     pc_q, pc_d;
    logic [7:0]     ir_q, ir_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           halted_q, halted_d;
    logic           err_q, err_d;
    logic [7:0]     stack_q [Entries];

    logic           stk_we;
    logic [SPW-1:0] stk_waddr;
    logic [7:0]     stk_wdata;

    logic [2:0]     opcode;
    logic [4:0]     opa;
    logic [SPW-1:0] sp_m1, sp_m2;
    logic [7:0]     tos_val, nos_val, alu_res;

    assign opcode = ir_q[7:5];
    assign opa    = ir_q[4:0];
    assign sp_m1  = sp_q - SpOne;
    assign sp_m2  = sp_q - SpTwo;

    assign tos_val = (sp_q == '0) ? 8'h00 : stack_q[sp_m1];
    assign nos_val = stack_q[sp_m2];

    // a is the deeper entry (nos), b the top (tos); results wrap mod 256.
    always_comb begin
        alu_res = 8'h00;
        unique case (opcode)
            OpAdd:   alu_res = nos_val + tos_val;
            OpSub:   alu_res = nos_val - tos_val;
            OpAnd:   alu_res = nos_val & tos_val;
            default: alu_res = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        sp_d      = sp_q;
        halted_d  = halted_q;
        err_d     = err_q;
        stk_we    = 1'b0;
        stk_waddr = sp_q;
        stk_wdata = mem_rdata;

        unique case (state_q)
            StFetch: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 5'd1;
                state_d = StDecode;
            end
            StDecode: begin
                // Fault checks precede any state change, so a faulting instruction leaves
                // sp, the stack and pc exactly as FETCH left them.
                unique case (opcode)
                    OpAdd, OpSub, OpAnd: begin
                        if (sp_q < SpTwo) begin
                            err_d    = 1'b1;
                            halted_d = 1'b1;
                            state_d  = StStop;
                        end else begin
                            stk_we    = 1'b1;
                            stk_waddr = sp_m2;
                            stk_wdata = alu_res;
                            sp_d      = sp_m1;
                            state_d   = StFetch;
                        end
                    end
                    OpHalt: begin
                        halted_d = 1'b1;
                        state_d  = StStop;
                    end
                    OpPush: begin
                        if (sp_q == SpFull) begin
                            err_d    = 1'b1;
                            halted_d = 1'b1;
                            state_d  = StStop;
                        end else begin
                            state_d = StMem;
                        end
                    end
                    OpPop: begin
                        if (sp_q == '0) begin
                            err_d    = 1'b1;
                            halted_d = 1'b1;
                            state_d  = StStop;
                        end else begin
                            state_d = StMem;
                        end
                    end
                    OpJmp: begin
                        pc_d    = opa;
                        state_d = StFetch;
                    end
                    OpJz: begin
                        if (sp_q == '0) begin
                            err_d    = 1'b1;
                            halted_d = 1'b1;
                            state_d  = StStop;
                        end else begin
                            sp_d = sp_m1;
                            if (tos_val == 8'h00) begin
                                pc_d = opa;
                            end
                            state_d = StFetch;
                        end
                    end
                endcase
            end
            StMem: begin
                // Only PUSH and POP reach MEM.
                if (opcode == OpPush) begin
                    stk_we    = 1'b1;
                    stk_waddr = sp_q;
                    stk_wdata = mem_rdata;
                    sp_d      = sp_q + SpOne;
                end else begin
                    sp_d = sp_m1;
                end
                state_d = StFetch;
            end
            StStop: begin
                state_d = StStop;
            end
        endcase
    end

    // Strobes decode from the state register, so an asynchronous reset drops a pending write
    // before its edge arrives.
    always_comb begin
        mem_addr  = pc_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = tos_val;
        unique case (state_q)
            StFetch: mem_rd = 1'b1;
            StMem: begin
                mem_addr = opa;
                if (opcode == OpPush) begin
                    mem_rd = 1'b1;
                end else begin
                    mem_wr = 1'b1;
                end
            end
            StDecode, StStop: begin
                mem_rd = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StFetch;
            pc_q     <= 5'd0;
            ir_q     <= 8'h00;
            sp_q     <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            sp_q     <= sp_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (stk_we) begin
            stack_q[stk_waddr] <= stk_wdata;
        end
    end

    assign halted = halted_q;
    assign err    = err_q;
    assign pc     = pc_q;
    assign sp     = sp_q;
    assign tos    = tos_val;

endmodule
